// File: rtl/cmdout_collector.sv
// Collects variable-length command packets from one AXI-Stream into per-accelerator
// ring subqueues of a shared 64-bit BRAM; arguments first, header (with valid byte) last.
module cmdout_collector #(
  parameter int          MAX_ACCS     = 16,
  parameter int          SUBQUEUE_LEN = 64,
  parameter logic [7:0]  VALID_BYTE   = 8'h80,
  localparam int         TW           = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1,
  localparam int         IW           = $clog2(SUBQUEUE_LEN)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          cmdout_in_tvalid,
  output logic          cmdout_in_tready,
  input  logic [TW-1:0] cmdout_in_tid,
  input  logic [63:0]   cmdout_in_tdata,
  input  logic          cmdout_in_tlast,
  output logic          mem_en,
  output logic [7:0]    mem_we,
  output logic [31:0]   mem_addr,
  output logic [63:0]   mem_din,
  input  logic [63:0]   mem_dout,
  output logic          cmd_done,
  output logic [TW-1:0] cmd_done_tid,
  output logic          err_len,
  output logic          err_frame
);

  typedef enum logic [2:0] {
    S_IDLE, S_HRD, S_HCHK, S_ARD, S_ACHK, S_AWAIT, S_PUB, S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   hdr_q, hdr_d;
  logic [TW-1:0] tid_q, tid_d;
  logic [7:0]    n_q, n_d;
  logic [IW-1:0] base_q, base_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          drop_pub_q, drop_pub_d;
  logic          err_len_q, err_len_d;
  logic          err_frame_q, err_frame_d;
  logic [IW-1:0] wr_ptr_q [MAX_ACCS];
  logic [IW-1:0] wr_ptr_d [MAX_ACCS];

  function automatic logic [31:0] slot_addr(input logic [TW-1:0] t, input logic [IW-1:0] i);
    return ((32'(t) << IW) | 32'(i)) << 3;
  endfunction

  assign err_len   = err_len_q;
  assign err_frame = err_frame_q;

  // Next-state and output decode; all outputs held low while aresetn is asserted
  always_comb begin
    state_d          = state_q;
    hdr_d            = hdr_q;
    tid_d            = tid_q;
    n_d              = n_q;
    base_d           = base_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    drop_pub_d       = drop_pub_q;
    err_len_d        = err_len_q;
    err_frame_d      = err_frame_q;
    wr_ptr_d         = wr_ptr_q;
    cmdout_in_tready = 1'b0;
    mem_en           = 1'b0;
    mem_we           = 8'h00;
    mem_addr         = 32'h0000_0000;
    mem_din          = 64'h0;
    cmd_done         = 1'b0;
    cmd_done_tid     = {TW{1'b0}};
    if (aresetn) begin
      case (state_q)
        S_IDLE: begin
          cmdout_in_tready = 1'b1;
          if (cmdout_in_tvalid) begin
            hdr_d  = cmdout_in_tdata;
            tid_d  = cmdout_in_tid;
            n_d    = cmdout_in_tdata[15:8];
            base_d = wr_ptr_q[cmdout_in_tid];
            if ({24'd0, cmdout_in_tdata[15:8]} > 32'(SUBQUEUE_LEN - 1)) begin
              err_len_d  = 1'b1;
              drop_pub_d = 1'b0;
              state_d    = cmdout_in_tlast ? S_IDLE : S_DROP;
            end else begin
              state_d = S_HRD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HRD: begin
          mem_en   = 1'b1;
          mem_addr = slot_addr(tid_q, base_q);
          state_d  = S_HCHK;
        end
        S_HCHK: begin
          // idx is primed even for N=0 so PUB can always advance wr_ptr to idx
          if (mem_dout != 64'h0) begin
            state_d = S_HRD;
          end else if (n_q == 8'h00) begin
            idx_d   = base_q + IW'(1);
            state_d = S_PUB;
          end else begin
            idx_d   = base_q + IW'(1);
            cnt_d   = 8'h00;
            state_d = S_ARD;
          end
        end
        S_ARD: begin
          mem_en   = 1'b1;
          mem_addr = slot_addr(tid_q, idx_q);
          state_d  = S_ACHK;
        end
        S_ACHK: begin
          state_d = (mem_dout != 64'h0) ? S_ARD : S_AWAIT;
        end
        S_AWAIT: begin
          cmdout_in_tready = 1'b1;
          if (cmdout_in_tvalid) begin
            mem_en   = 1'b1;
            mem_we   = 8'hFF;
            mem_addr = slot_addr(tid_q, idx_q);
            mem_din  = cmdout_in_tdata;
            idx_d    = idx_q + IW'(1);
            cnt_d    = cnt_q + 8'd1;
            if ((cnt_q + 8'd1) == n_q) begin
              if (cmdout_in_tlast) begin
                state_d = S_PUB;
              end else begin
                err_frame_d = 1'b1;
                drop_pub_d  = 1'b1;
                state_d     = S_DROP;
              end
            end else begin
              err_frame_d = err_frame_q | cmdout_in_tlast;
              state_d     = S_ARD;
            end
          end else begin
            state_d = S_AWAIT;
          end
        end
        S_PUB: begin
          mem_en           = 1'b1;
          mem_we           = 8'hFF;
          mem_addr         = slot_addr(tid_q, base_q);
          mem_din          = {hdr_q[63:8], VALID_BYTE};
          wr_ptr_d[tid_q]  = idx_q;
          cmd_done         = 1'b1;
          cmd_done_tid     = tid_q;
          state_d          = S_IDLE;
        end
        S_DROP: begin
          cmdout_in_tready = 1'b1;
          if (cmdout_in_tvalid && cmdout_in_tlast) begin
            state_d = drop_pub_q ? S_PUB : S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and pointer registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      hdr_q       <= 64'h0;
      tid_q       <= {TW{1'b0}};
      n_q         <= 8'h00;
      base_q      <= {IW{1'b0}};
      idx_q       <= {IW{1'b0}};
      cnt_q       <= 8'h00;
      drop_pub_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_frame_q <= 1'b0;
      for (int i = 0; i < MAX_ACCS; i++) begin
        wr_ptr_q[i] <= {IW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      tid_q       <= tid_d;
      n_q         <= n_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      drop_pub_q  <= drop_pub_d;
      err_len_q   <= err_len_d;
      err_frame_q <= err_frame_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

endmodule
